lw_hazard_stall_unit: RTL

LW_HAZARD_STALL_UNIT -- requirements
Module: lw_hazard_stall_unit

---
 rtl/lw_hazard_stall_unit_pkg.sv | 16 +
 rtl/lw_hazard_stall_unit_compare.sv | 30 +++
 rtl/lw_hazard_stall_unit.sv | 87 ++++++++
 3 files changed

// File: rtl/lw_hazard_stall_unit_pkg.sv
// Shared definitions for the load-use hazard stall unit.
//   REG_AW_DEF : default register-specifier width
//   state_t    : RUN/STALL encoding of the 1-bit stall FSM
//   ZERO_REG   : hard-wired zero register specifier (never a real dependency)
package lw_hazard_stall_unit_pkg;

  localparam int REG_AW_DEF = 5;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  localparam logic [REG_AW_DEF-1:0] ZERO_REG = '0;

endpackage

// File: rtl/lw_hazard_stall_unit_compare.sv
// Pure combinational load-use hazard detector.
// Ports:
//   id_ex_lw, id_ex_rt          : load flag and destination of the instruction in EX
//   if_id_rs, if_id_rt          : source fields of the instruction in ID
//   if_id_uses_rt, if_id_valid  : ID actually reads rt / ID holds a real instruction
//   hazard                      : ID instruction needs the load result next cycle
module lw_hazard_compare
  import lw_hazard_stall_unit_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              id_ex_lw,
  input  logic [REG_AW-1:0] id_ex_rt,
  input  logic [REG_AW-1:0] if_id_rs,
  input  logic [REG_AW-1:0] if_id_rt,
  input  logic              if_id_uses_rt,
  input  logic              if_id_valid,
  output logic              hazard
);

  logic rs_hit, rt_hit, dst_live;

  // r0 can never carry a load result, so a match on it is not a dependency
  assign dst_live = (id_ex_rt != REG_AW'(ZERO_REG));
  assign rs_hit   = (id_ex_rt == if_id_rs);
  // rt only matters for formats that read it (R-type, sw, beq)
  assign rt_hit   = if_id_uses_rt & (id_ex_rt == if_id_rt);
  assign hazard   = id_ex_lw & if_id_valid & dst_live & (rs_hit | rt_hit);

endmodule

// File: rtl/lw_hazard_stall_unit.sv
// Load-use hazard stall unit: holds PC and IF/ID and injects one bubble into
// ID/EX when the ID instruction depends on a load currently in EX.
// Optional build macro: HAZARD_STAT_EN adds the CNT_W parameter, a saturating
// stall tally and the stall_count port.
// Ports:
//   clock, reset_n      : rising-edge clock, async active-low reset
//   id_ex_lw, id_ex_rt  : load flag / destination in ID/EX
//   if_id_rs, if_id_rt  : source fields in IF/ID
//   if_id_uses_rt       : IF/ID instruction reads rt
//   if_id_valid         : IF/ID holds a real instruction
//   flush               : taken branch/jump squashing IF/ID (wins over a hazard)
//   pc_write_en         : PC update enable
//   if_id_write_en      : IF/ID load enable
//   id_ex_bubble        : zero all ID/EX control inputs
//   stall_count         : stall tally, saturating (HAZARD_STAT_EN only)
module lw_hazard_stall_unit
  import lw_hazard_stall_unit_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
`ifdef HAZARD_STAT_EN
  ,parameter int CNT_W = 16
`endif
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              id_ex_lw,
  input  logic [REG_AW-1:0] id_ex_rt,
  input  logic [REG_AW-1:0] if_id_rs,
  input  logic [REG_AW-1:0] if_id_rt,
  input  logic              if_id_uses_rt,
  input  logic              if_id_valid,
  input  logic              flush,
  output logic              pc_write_en,
  output logic              if_id_write_en,
  output logic              id_ex_bubble
`ifdef HAZARD_STAT_EN
  ,output logic [CNT_W-1:0] stall_count
`endif
);

  state_t state_q, state_d;
  logic   hazard;
  logic   stall_go;

  lw_hazard_compare #(.REG_AW(REG_AW)) u_cmp (
    .id_ex_lw      (id_ex_lw),
    .id_ex_rt      (id_ex_rt),
    .if_id_rs      (if_id_rs),
    .if_id_rt      (if_id_rt),
    .if_id_uses_rt (if_id_uses_rt),
    .if_id_valid   (if_id_valid),
    .hazard        (hazard)
  );

  // Stall only from RUN; STALL always releases so each pair costs one cycle.
  // reset_n gates it so outputs sit at run values while reset is held.
  assign stall_go = reset_n & (state_q == ST_RUN) & hazard & ~flush;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_RUN;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = ST_RUN;
    if (stall_go) state_d = ST_STALL;
  end

  always_comb begin
    pc_write_en    = 1'b1;
    if_id_write_en = 1'b1;
    id_ex_bubble   = 1'b0;
    if (stall_go) begin
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      id_ex_bubble   = 1'b1;
    end
  end

`ifdef HAZARD_STAT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                          stall_count <= '0;
    else if (stall_go && (~stall_count != '0)) stall_count <= stall_count + 1'b1;
  end
`endif

endmodule
